mem_stage_ctrl: RTL and testbench
=================================

# mem_stage_ctrl

Memory-access stage controller of the 5-stage pipeline. Consumes the EX/MEM pipeline register outputs and performs loads and stores over a ready/valid data-memory port. Stalls the upstream pipeline while an access is outstanding, resolves branch/jump redirect, and drives the MEM/WB pipeline register.

## Interface
- DATA_W, 32, data and address width
- REG_W, 5, destination register index width

- clk  in  1  pipeline clock, rising edge
- startin  in  1  reset; asynchronous, active-low
- jump, branch, memread, memtoreg, memwrite, regwrite  in  1 each  control bits from EX/MEM
- zero  in  1  ALU zero flag from EX/MEM
- aluResult  in  DATA_W  ALU result / memory byte address
- read2  in  DATA_W  store data
- regDstMux  in  REG_W  destination register
- dmem_req  out  1  access request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  DATA_W  word address {aluResult[31:2],2'b00}
- dmem_wdata  out  DATA_W  = read2
- dmem_ready  in  1  memory accepts request this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  DATA_W  read data
- stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- pcSrc  out  1  branch taken, = branch & zero (combinational)
- jumpOut  out  1  = jump (combinational)
- memtoregOut, regwriteOut  out  1  MEM/WB control
- readData, aluResultOut  out  DATA_W  MEM/WB data
- regDstOut  out  REG_W  MEM/WB destination

## Operation
- memop = memread | memwrite. If both are set, the access is a write and memread is ignored.
- FSM states:
  - IDLE: memop → REQ. Otherwise stay.
  - REQ: dmem_ready & dmem_we → DONE. dmem_ready & ~dmem_we → WAIT. Otherwise stay.
  - WAIT: dmem_rvalid → DONE, and dmem_rdata is captured into an internal rdata_q.
  - DONE: → IDLE unconditionally.
- dmem_req = (state == REQ). dmem_we, dmem_addr and dmem_wdata come from the EX/MEM inputs, which are stable because those inputs are stalled.
- stall = (IDLE & memop) | REQ | WAIT. stall is deasserted in DONE and for non-memory instructions.
- MEM/WB update on every edge:
  - stall = 0: load memtoreg, regwrite, aluResult, regDstMux. readData loads rdata_q in DONE for reads, otherwise 0.
  - stall = 1: bubble. regwriteOut and memtoregOut load 0; data fields hold.
- dmem_rvalid is sampled only in WAIT and ignored in IDLE, REQ and DONE.
- aluResult[1:0] is dropped; only word accesses exist.

## Timing
- Reset (startin = 0, asynchronous): state = IDLE. All registered outputs = 0. dmem_req drops immediately.
- Reset mid-access abandons the transaction. After release the block starts in IDLE with no replay.
- Latency, counted in cycles with the instruction present at the EX/MEM outputs:
  - non-memory instruction: 1 cycle to MEM/WB.
  - store with ready on first REQ cycle: 3 cycles (IDLE, REQ, DONE).
  - load with rvalid on first WAIT cycle: 4 cycles.
- Each extra cycle of dmem_ready low adds 1 cycle, with the request held stable. Each extra cycle of dmem_rvalid low adds 1 cycle.
- pcSrc and jumpOut are not gated by stall. Branches and jumps are never memops, so they never coincide with a stall.
- Back-to-back memops: DONE releases stall. The next instruction appears in IDLE on the following cycle and starts its own access. There are no dead cycles beyond DONE.

## Structure
- Package mem_stage_pkg holds:
  - the state enum (IDLE, REQ, WAIT, DONE)
  - DATA_W and REG_W defaults
- Sub-module MEM_WB is the MEM/WB pipeline register, with inputs load and bubble. The FSM, stall logic and memory port stay in mem_stage_ctrl.

## Test plan
- Reset: hold startin = 0 with memwrite = 1. Required: dmem_req = 0, stall = 1, all MEM/WB outputs 0. Release reset; an access begins on the next edge.
- ALU op: regwrite = 1, aluResult = 0x2A, regDstMux = 10, no memop. Required: stall = 0; next edge regwriteOut = 1, aluResultOut = 0x2A, regDstOut = 10.
- Store: memwrite = 1, aluResult = 0x103, read2 = 8, ready held low 2 cycles. Required:
  - dmem_addr = 0x100, dmem_wdata = 8, dmem_we = 1, held for 3 REQ cycles.
  - stall high for 4 cycles.
  - bubbles (regwriteOut = 0) during the stall.
- Load: memread = 1, memtoreg = 1, regwrite = 1, rvalid 3 cycles after accept with rdata = 0xDEADBEEF. Required:
  - readData = 0xDEADBEEF, regwriteOut = 1 exactly once.
  - dmem_rvalid pulsed during REQ is ignored.
- Branch: branch = 1, zero = 1. Required: pcSrc = 1 in the same cycle, stall = 0. With zero = 0: pcSrc = 0. With jump = 1: jumpOut = 1.
- Reset mid-load: assert startin = 0 in WAIT. Required: dmem_req = 0, state IDLE, no MEM/WB writeback of the load.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared state encoding and default widths for the memory-access stage.
package mem_stage_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF = 5;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
endpackage

// File: rtl/mem_stage_ctrl_mem_wb.sv
// mem_wb: MEM/WB pipeline register; a bubble clears the control bits while data fields hold.
module mem_wb #(
  parameter int DATA_W = 32,
  parameter int REG_W = 5
) (
  input  logic              clk,
  input  logic              startin,
  input  logic              load,
  input  logic              bubble,
  input  logic              memtoreg,
  input  logic              regwrite,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] read_data,
  input  logic [REG_W-1:0]  reg_dst,
  output logic              memtoreg_q,
  output logic              regwrite_q,
  output logic [DATA_W-1:0] alu_result_q,
  output logic [DATA_W-1:0] read_data_q,
  output logic [REG_W-1:0]  reg_dst_q
);
  always_ff @(posedge clk or negedge startin)
    if (!startin) begin
      memtoreg_q <= 1'b0;
      regwrite_q <= 1'b0;
      alu_result_q <= '0;
      read_data_q <= '0;
      reg_dst_q <= '0;
    end else if (bubble) begin
      memtoreg_q <= 1'b0;
      regwrite_q <= 1'b0;
    end else if (load) begin
      memtoreg_q <= memtoreg;
      regwrite_q <= regwrite;
      alu_result_q <= alu_result;
      read_data_q <= read_data;
      reg_dst_q <= reg_dst;
    end
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-access stage; runs loads/stores over a ready/valid port,
// stalls upstream while an access is outstanding and feeds the MEM/WB register.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W = REG_W_DEF
) (
  input  logic              clk,
  input  logic              startin,
  input  logic              jump,
  input  logic              branch,
  input  logic              memread,
  input  logic              memtoreg,
  input  logic              memwrite,
  input  logic              regwrite,
  input  logic              zero,
  input  logic [DATA_W-1:0] aluResult,
  input  logic [DATA_W-1:0] read2,
  input  logic [REG_W-1:0]  regDstMux,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall,
  output logic              pcSrc,
  output logic              jumpOut,
  output logic              memtoregOut,
  output logic              regwriteOut,
  output logic [DATA_W-1:0] readData,
  output logic [DATA_W-1:0] aluResultOut,
  output logic [REG_W-1:0]  regDstOut
);
  state_t state, state_nxt;
  logic [DATA_W-1:0] rdata_q;
  logic memop;
  assign memop = memread | memwrite;
  always_ff @(posedge clk or negedge startin)
    if (!startin) begin
      state <= IDLE;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == WAIT && dmem_rvalid) rdata_q <= dmem_rdata;
    end
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (memop ? REQ : IDLE)
              : state == REQ  ? (dmem_ready ? (dmem_we ? DONE : WAIT) : REQ)
              : state == WAIT ? (dmem_rvalid ? DONE : WAIT)
              : IDLE;
  end
  // A write wins when both memread and memwrite are set.
  assign dmem_we = memwrite;
  assign dmem_req = state == REQ;
  assign dmem_addr = aluResult & ~DATA_W'(3);
  assign dmem_wdata = read2;
  assign stall = (state == IDLE && memop) || state == REQ || state == WAIT;
  assign pcSrc = branch & zero;
  assign jumpOut = jump;
  mem_wb #(.DATA_W(DATA_W), .REG_W(REG_W)) u_mem_wb (
    .clk(clk),
    .startin(startin),
    .load(!stall),
    .bubble(stall),
    .memtoreg(memtoreg),
    .regwrite(regwrite),
    .alu_result(aluResult),
    .read_data(state == DONE && !memwrite ? rdata_q : '0),
    .reg_dst(regDstMux),
    .memtoreg_q(memtoregOut),
    .regwrite_q(regwriteOut),
    .alu_result_q(aluResultOut),
    .read_data_q(readData),
    .reg_dst_q(regDstOut)
  );
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: randomized and directed checks of the memory-access stage against a latency/writeback model.
module tb_mem_stage_ctrl;
  logic clk = 0, startin = 0;
  logic jump = 0, branch = 0, memread = 0, memtoreg = 0, memwrite = 0, regwrite = 0, zero = 0;
  logic [31:0] aluResult = 0, read2 = 0, dmem_rdata = 0;
  logic [4:0] regDstMux = 0;
  logic dmem_ready = 0, dmem_rvalid = 0;
  logic dmem_req, dmem_we, stall, pcSrc, jumpOut, memtoregOut, regwriteOut;
  logic [31:0] dmem_addr, dmem_wdata, readData, aluResultOut;
  logic [4:0] regDstOut;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl dut (
    .clk(clk), .startin(startin), .jump(jump), .branch(branch), .memread(memread),
    .memtoreg(memtoreg), .memwrite(memwrite), .regwrite(regwrite), .zero(zero),
    .aluResult(aluResult), .read2(read2), .regDstMux(regDstMux),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .stall(stall), .pcSrc(pcSrc), .jumpOut(jumpOut), .memtoregOut(memtoregOut),
    .regwriteOut(regwriteOut), .readData(readData), .aluResultOut(aluResultOut),
    .regDstOut(regDstOut)
  );

  task automatic nop();
    {jump, branch, memread, memtoreg, memwrite, regwrite, zero} = '0;
    {dmem_ready, dmem_rvalid} = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    memwrite = 1;
    #12;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", dmem_req); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall got %b want 1", stall); end
    checks++;
    if ({memtoregOut, regwriteOut, readData, aluResultOut, regDstOut} !== '0) begin
      errors++; $display("FAIL reset_memwb got %b %b %h %h %h want zeros", memtoregOut, regwriteOut, readData, aluResultOut, regDstOut);
    end
    startin = 1;
    step();
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL reset_release_req got %b want 1", dmem_req); end
    startin = 0;
    #1;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_async_req got %b want 0", dmem_req); end
    nop();
    startin = 1;
    step();
  endtask

  task automatic test_alu();
    regwrite = 1; aluResult = 32'h2A; regDstMux = 5'd10;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall got %b want 0", stall); end
    step();
    checks++;
    if ({regwriteOut, aluResultOut, regDstOut} !== {1'b1, 32'h2A, 5'd10}) begin
      errors++; $display("FAIL alu_wb got %b %h %0d want 1 0000002a 10", regwriteOut, aluResultOut, regDstOut);
    end
    nop();
  endtask

  task automatic test_store();
    int stalls = 0;
    memwrite = 1; regwrite = 1; aluResult = 32'h103; read2 = 32'd8; regDstMux = 5'd3;
    for (int c = 0; c < 5; c++) begin
      dmem_ready = c == 3;
      #1;
      stalls += int'(stall);
      checks++; if (dmem_req !== (c >= 1 && c <= 3)) begin errors++; $display("FAIL store_req c=%0d got %b", c, dmem_req); end
      if (c >= 1 && c <= 3) begin
        checks++;
        if ({dmem_addr, dmem_wdata, dmem_we} !== {32'h100, 32'd8, 1'b1}) begin
          errors++; $display("FAIL store_port c=%0d got %h %h %b want 00000100 00000008 1", c, dmem_addr, dmem_wdata, dmem_we);
        end
      end
      @(posedge clk); #1;
      checks++; if (regwriteOut !== (c == 4)) begin errors++; $display("FAIL store_bubble c=%0d got %b want %b", c, regwriteOut, c == 4); end
    end
    checks++; if (stalls != 4) begin errors++; $display("FAIL store_stall_cycles got %0d want 4", stalls); end
    nop();
  endtask

  task automatic test_load();
    int wb = 0;
    logic [31:0] got = 0;
    memread = 1; memtoreg = 1; regwrite = 1; aluResult = 32'h40; regDstMux = 5'd7;
    for (int c = 0; c < 9; c++) begin
      if (c == 7) nop();
      dmem_ready = c == 2;
      dmem_rvalid = c == 1 || c == 5;
      dmem_rdata = c == 5 ? 32'hDEADBEEF : 32'h12345678;
      step();
      if (regwriteOut) begin wb++; got = readData; end
    end
    checks++; if (wb != 1) begin errors++; $display("FAIL load_wb_count got %0d want 1", wb); end
    checks++; if (got !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data got %h want deadbeef", got); end
    nop();
  endtask

  task automatic test_branch();
    for (int n = 0; n < 8; n++) begin
      branch = n[0]; zero = n[1]; jump = n[2];
      #1;
      checks++;
      if ({pcSrc, jumpOut, stall} !== {n[0] & n[1], n[2], 1'b0}) begin
        errors++; $display("FAIL branch n=%0d got pcSrc=%b jumpOut=%b stall=%b", n, pcSrc, jumpOut, stall);
      end
      step();
    end
    nop();
  endtask

  task automatic test_reset_mid_load();
    memread = 1; memtoreg = 1; regwrite = 1; aluResult = 32'h80;
    step();
    dmem_ready = 1;
    step();
    dmem_ready = 0;
    startin = 0;
    #1;
    checks++; if ({dmem_req, regwriteOut, readData} !== '0) begin
      errors++; $display("FAIL midreset got req=%b rw=%b rd=%h want zeros", dmem_req, regwriteOut, readData);
    end
    dmem_rvalid = 1; dmem_rdata = 32'hCAFEF00D;
    #2;
    nop();
    startin = 1;
    regwrite = 1; aluResult = 32'h55; regDstMux = 5'd9;
    @(posedge clk); #1;
    checks++;
    if ({regwriteOut, memtoregOut, aluResultOut, readData} !== {1'b1, 1'b0, 32'h55, 32'h0}) begin
      errors++; $display("FAIL midreset_after got rw=%b mt=%b alu=%h rd=%h want 1 0 00000055 00000000", regwriteOut, memtoregOut, aluResultOut, readData);
    end
    nop();
  endtask

  task automatic test_back_to_back();
    logic [31:0] p_alu = 0, p_rd = 0;
    logic [4:0] p_dst = 0;
    startin = 0; #2; startin = 1;
    step();
    for (int n = 0; n < 60; n++) begin
      logic mr, mw, mem, ld;
      logic [31:0] rd, e_rd;
      int rdly, vdly, s;
      mr = 1'($urandom % 2); mw = 1'($urandom % 2);
      if ($urandom % 3 == 0) begin mr = 0; mw = 0; end
      mem = mr | mw; ld = mr & ~mw;
      rdly = $urandom % 3; vdly = $urandom % 3; rd = $urandom;
      s = mw ? 2 + rdly : ld ? 3 + rdly + vdly : 0;
      e_rd = ld ? rd : 32'h0;
      memread = mr; memwrite = mw; memtoreg = 1'($urandom % 2); regwrite = 1'($urandom % 2);
      aluResult = $urandom; read2 = $urandom; regDstMux = 5'($urandom);
      for (int c = 0; c <= s; c++) begin
        dmem_ready = mem && c == 1 + rdly;
        dmem_rvalid = (ld && c == 2 + rdly + vdly) ? 1'b1 : (c <= 1 + rdly ? 1'($urandom % 2) : 1'b0);
        dmem_rdata = (ld && c == 2 + rdly + vdly) ? rd : $urandom;
        #1;
        checks++; if (stall !== (c < s)) begin errors++; $display("FAIL b2b_stall n=%0d c=%0d got %b want %b", n, c, stall, c < s); end
        checks++;
        if (dmem_req !== (mem && c >= 1 && c <= 1 + rdly)) begin
          errors++; $display("FAIL b2b_req n=%0d c=%0d got %b", n, c, dmem_req);
        end
        if (mem && c >= 1 && c <= 1 + rdly) begin
          checks++;
          if ({dmem_addr, dmem_we, dmem_wdata} !== {aluResult & 32'hFFFF_FFFC, mw, read2}) begin
            errors++; $display("FAIL b2b_port n=%0d got %h %b %h", n, dmem_addr, dmem_we, dmem_wdata);
          end
        end
        @(posedge clk); #1;
        checks++;
        if (c < s) begin
          if ({regwriteOut, memtoregOut, aluResultOut, readData, regDstOut} !== {2'b00, p_alu, p_rd, p_dst}) begin
            errors++; $display("FAIL b2b_bubble n=%0d c=%0d got %b%b %h %h %h want 00 %h %h %h", n, c,
              regwriteOut, memtoregOut, aluResultOut, readData, regDstOut, p_alu, p_rd, p_dst);
          end
        end else begin
          if ({regwriteOut, memtoregOut, aluResultOut, readData, regDstOut} !== {regwrite, memtoreg, aluResult, e_rd, regDstMux}) begin
            errors++; $display("FAIL b2b_wb n=%0d got %b%b %h %h %h want %b%b %h %h %h", n,
              regwriteOut, memtoregOut, aluResultOut, readData, regDstOut, regwrite, memtoreg, aluResult, e_rd, regDstMux);
          end
          p_alu = aluResult; p_rd = e_rd; p_dst = regDstMux;
        end
      end
    end
    nop();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_branch();
    test_reset_mid_load();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
